sram_req_ctrl: RTL

Request-side controller placed directly upstream of the single-port `sram` macro. It converts a valid/ready request stream into the SRAM's `req`/`we`/`addr`/`wdata`/`be` strobes and absorbs the SRAM's one-cycle read latency. Every accepted request produces exactly one in-order response. Responses are held in a small FIFO so the consumer can apply backpressure without dropping read data.

---
 rtl/sram_req_ctrl_pkg.sv | 16 +
 rtl/sram_rsp_fifo.sv | 65 ++++++
 rtl/sram_req_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/sram_req_ctrl_pkg.sv
// Shared types and helpers for the SRAM request controller.
package sram_ctrl_pkg;

    typedef enum logic {
        PEND_IDLE = 1'b0,
        PEND_BUSY = 1'b1
    } pend_state_e;

    // A new request may be accepted only if its response is guaranteed a FIFO slot.
    function automatic logic credit_ok(input int unsigned count,
                                       input int unsigned pending,
                                       input int unsigned depth);
        return (count + pending) < depth;
    endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// Synchronous response FIFO; pointers wrap modulo DEPTH, full/empty from count.
module sram_rsp_fifo #(
    parameter  int WIDTH = 65,
    parameter  int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    // Status flags and qualified push/pop strobes.
    always_comb begin
        full_o  = (count == CNT_W'(DEPTH));
        empty_o = (count == '0);
        do_push = push_i & ~full_o;
        do_pop  = pop_i & ~empty_o;
        count_o = count;
        rdata_o = mem[rd_ptr];
    end

    // Storage, pointers and occupancy; storage is cleared so the head reads 0 after reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata_i;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/sram_req_ctrl.sv
// Request-side controller for the single-port sram macro.
// Optional macro SRAM_REQ_CTRL_ERR_EN: out-of-range addresses get an error
// response instead of an SRAM access.
//
// state     | meaning
// PEND_IDLE | no SRAM access issued last cycle
// PEND_BUSY | access issued last cycle; its response is pushed this cycle
module sram_req_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter  int DATA_WIDTH = 64,
    parameter  int NUM_WORDS  = 1024,
    parameter  int RSP_DEPTH  = 4,
    localparam int ADDR_WIDTH = $clog2(NUM_WORDS)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    input  logic [DATA_WIDTH-1:0] req_be_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  sram_req_o,
    output logic                  sram_we_o,
    output logic [ADDR_WIDTH-1:0] sram_addr_o,
    output logic [DATA_WIDTH-1:0] sram_wdata_o,
    output logic [DATA_WIDTH-1:0] sram_be_o,
    input  logic [DATA_WIDTH-1:0] sram_rdata_i
);

    localparam int CNT_W = $clog2(RSP_DEPTH + 1);

    typedef struct packed {
        logic                  err;
        logic [DATA_WIDTH-1:0] rdata;
    } rsp_entry_t;

    pend_state_e state_q;
    pend_state_e state_d;
    logic        is_write_q;
    logic        err_q;
    logic        acc;
    logic        req_err;
    logic        push;
    rsp_entry_t  push_entry;
    rsp_entry_t  head_entry;
    logic        fifo_full;
    logic        fifo_empty;
    logic [CNT_W-1:0] fifo_count;

`ifdef SRAM_REQ_CTRL_ERR_EN
    assign req_err = (32'(req_addr_i) >= 32'(NUM_WORDS));
`else
    assign req_err = 1'b0;
`endif

    // Credit-based ready from registered state only; SRAM strobes follow the accepted request.
    always_comb begin
        req_ready_o  = credit_ok(32'(fifo_count), 32'(state_q == PEND_BUSY), RSP_DEPTH);
        acc          = req_valid_i & req_ready_o;
        sram_req_o   = acc & ~req_err;
        sram_we_o    = req_we_i;
        sram_addr_o  = req_addr_i;
        sram_wdata_o = req_wdata_i;
        sram_be_o    = req_be_i;
    end

    // Pending stage next state and the response entry pushed while busy.
    always_comb begin
        state_d          = state_q;
        push             = 1'b0;
        push_entry.err   = err_q;
        push_entry.rdata = (is_write_q | err_q) ? '0 : sram_rdata_i;
        case (state_q)
            PEND_IDLE: if (acc) state_d = PEND_BUSY;
            PEND_BUSY: begin
                push = ~fifo_full;
                if (!acc) state_d = PEND_IDLE;
            end
            default:   state_d = PEND_IDLE;
        endcase
    end

    // Pending stage register; captures request kind on every accept.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= PEND_IDLE;
            is_write_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (acc) begin
                is_write_q <= req_we_i;
                err_q      <= req_err;
            end
        end
    end

    sram_rsp_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (RSP_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .wdata_i (push_entry),
        .pop_i   (rsp_valid_o & rsp_ready_i),
        .rdata_o (head_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Response outputs come from the FIFO head, forced to 0 when nothing is held.
    always_comb begin
        rsp_valid_o = ~fifo_empty;
        rsp_rdata_o = rsp_valid_o ? head_entry.rdata : '0;
        rsp_err_o   = rsp_valid_o & head_entry.err;
    end

endmodule
